// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, FSM states and datapath select encodings for the multicycle core
package riscv_pkg;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] A_PC      = 2'b00;
  localparam logic [1:0] A_OLDPC   = 2'b01;
  localparam logic [1:0] A_RS1     = 2'b10;
  localparam logic [1:0] B_RS2     = 2'b00;
  localparam logic [1:0] B_IMM     = 2'b01;
  localparam logic [1:0] B_FOUR    = 2'b10;
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;
  localparam logic [1:0] WB_IMM    = 2'b11;
  localparam logic       PC_ALU    = 1'b0;
  localparam logic       PC_ALUOUT = 1'b1;
  function automatic logic legal_op(input logic [6:0] op);
    return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_LUI};
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on mem_ready and flags the last allowed one
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic expire
);
  localparam int W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || !active || ready) cnt <= '0;
    else cnt <= cnt + W'(1);
  // expire fires during the final waiting cycle so a late mem_ready still wins
  assign expire = (MEM_TIMEOUT != 0) && active && !ready && (cnt == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: sequencing FSM driving the shared datapath of a multi-cycle RV32I subset
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_o
);
  state_t state, nxt;
  logic expire, retire, waiting;
  logic [CNT_W-1:0] cnt;
  assign waiting = state == S_FETCH || state == S_MEM;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .active(waiting),
    .ready (mem_ready),
    .expire(expire)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt + CNT_W'(retire);
    end
  assign retired = rst ? '0 : cnt;
  assign state_o = rst ? 3'd0 : state;
  always_comb begin
    {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src} = '0;
    {alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, trap} = '0;
    nxt    = state;
    retire = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = A_PC;
        alu_src_b = B_FOUR;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        pc_src    = PC_ALU;
        nxt       = mem_ready ? S_DECODE : expire ? S_TRAP : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        alu_op    = ALU_ADD;
        nxt       = legal_op(opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC:
        case (opcode)
          OP_R: begin
            {alu_src_a, alu_src_b, alu_op} = {A_RS1, B_RS2, ALU_FUNCT};
            nxt = S_WB;
          end
          OP_ADDI: begin
            {alu_src_a, alu_src_b, alu_op} = {A_RS1, B_IMM, ALU_ADD};
            nxt = S_WB;
          end
          OP_LW, OP_SW: begin
            {alu_src_a, alu_src_b, alu_op} = {A_RS1, B_IMM, ALU_ADD};
            nxt = S_MEM;
          end
          OP_BEQ: begin
            {alu_src_a, alu_src_b, alu_op} = {A_RS1, B_RS2, ALU_SUB};
            pc_write = zero;
            pc_src   = PC_ALUOUT;
            retire   = 1'b1;
            nxt      = S_FETCH;
          end
          OP_JAL: begin
            reg_write = 1'b1;
            wb_sel    = WB_PC;
            pc_write  = 1'b1;
            pc_src    = PC_ALUOUT;
            retire    = 1'b1;
            nxt       = S_FETCH;
          end
          OP_LUI: begin
            reg_write = 1'b1;
            wb_sel    = WB_IMM;
            retire    = 1'b1;
            nxt       = S_FETCH;
          end
          default: nxt = S_TRAP;
        endcase
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = opcode == OP_SW;
        retire  = mem_ready && opcode == OP_SW;
        nxt     = mem_ready ? (opcode == OP_SW ? S_FETCH : S_WB) : expire ? S_TRAP : S_MEM;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = opcode == OP_LW ? WB_MEM : WB_ALU;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: nxt = S_TRAP;
    endcase
    if (rst) begin
      {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src} = '0;
      {alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, trap} = '0;
      retire = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-instruction trace model checked cycle by cycle against the controller
module tb_multicycle_ctrl;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg_write, trap;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [31:0] retired;
  logic [2:0]  state_o;
  typedef struct packed {
    logic [2:0] st;
    logic req, we, sel, irw, pcw, pcs;
    logic [1:0] a, b, op;
    logic rw;
    logic [1:0] wb;
    logic tr;
  } ctl_t;
  ctl_t act;
  ctl_t q_c[$];
  bit   q_r[$], q_z[$], q_ret[$];
  int   vectors = 0, errs = 0;
  logic [31:0] exp_ret = '0;
  logic [6:0]  cur_op = '0;
  logic [6:0]  legal[7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b1101111, 7'b0110111};
  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .trap(trap),
    .retired(retired), .state_o(state_o)
  );
  assign act = {state_o, mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, trap};
  always #5 clk = ~clk;
  task automatic push(input ctl_t c, input bit r, input bit z, input bit ret);
    q_c.push_back(c); q_r.push_back(r); q_z.push_back(z); q_ret.push_back(ret);
  endtask
  task automatic play(input string name);
    while (q_c.size() > 0) begin
      ctl_t c = q_c.pop_front();
      bit r = q_r.pop_front(), z = q_z.pop_front(), ret = q_ret.pop_front();
      @(negedge clk);
      rst = 1'b0; opcode = cur_op; mem_ready = r; zero = z;
      #1;
      vectors++;
      if (act !== c) begin
        errs++;
        $display("FAIL %s ctl: got %h expected %h (state got %0d expected %0d)", name, act, c, act.st, c.st);
      end
      vectors++;
      if (retired !== exp_ret) begin
        errs++;
        $display("FAIL %s retired: got %0d expected %0d", name, retired, exp_ret);
      end
      if (ret) exp_ret++;
    end
  endtask
  task automatic push_trap(input int n);
    ctl_t c;
    repeat (n) begin
      c = '0; c.st = 3'd5; c.tr = 1'b1;
      push(c, 1'($urandom), 1'($urandom), 1'b0);
    end
  endtask
  // Expected trace of one instruction: fw/mw = cycles mem_ready stays low in FETCH/MEM
  task automatic instr(input logic [6:0] op, input int fw, input int mw, input bit z, input string name);
    ctl_t c;
    bit ok = 1'b0;
    cur_op = op;
    foreach (legal[i]) if (legal[i] == op) ok = 1'b1;
    c = '0; c.st = 3'd0; c.req = 1'b1; c.b = 2'd2;
    for (int i = 0; i < fw && i < TO; i++) push(c, 1'b0, 1'($urandom), 1'b0);
    if (fw >= TO) begin push_trap(5); play(name); return; end
    c.irw = 1'b1; c.pcw = 1'b1;
    push(c, 1'b1, 1'($urandom), 1'b0);
    c = '0; c.st = 3'd1; c.a = 2'd1; c.b = 2'd1;
    push(c, 1'($urandom), 1'($urandom), 1'b0);
    if (!ok) begin push_trap(5); play(name); return; end
    c = '0; c.st = 3'd2;
    if (op == 7'b1100011) begin
      c.a = 2'd2; c.op = 2'd1; c.pcw = z; c.pcs = 1'b1;
      push(c, 1'($urandom), z, 1'b1);
    end else if (op == 7'b1101111) begin
      c.rw = 1'b1; c.wb = 2'd2; c.pcw = 1'b1; c.pcs = 1'b1;
      push(c, 1'($urandom), 1'($urandom), 1'b1);
    end else if (op == 7'b0110111) begin
      c.rw = 1'b1; c.wb = 2'd3;
      push(c, 1'($urandom), 1'($urandom), 1'b1);
    end else begin
      c.a = 2'd2;
      c.b = op == 7'b0110011 ? 2'd0 : 2'd1;
      c.op = op == 7'b0110011 ? 2'd2 : 2'd0;
      push(c, 1'($urandom), 1'($urandom), 1'b0);
      if (op == 7'b0000011 || op == 7'b0100011) begin
        c = '0; c.st = 3'd3; c.req = 1'b1; c.sel = 1'b1; c.we = op == 7'b0100011;
        for (int i = 0; i < mw && i < TO; i++) push(c, 1'b0, 1'($urandom), 1'b0);
        if (mw >= TO) begin push_trap(5); play(name); return; end
        push(c, 1'b1, 1'($urandom), op == 7'b0100011);
      end
      if (op != 7'b0100011) begin
        c = '0; c.st = 3'd4; c.rw = 1'b1; c.wb = op == 7'b0000011 ? 2'd1 : 2'd0;
        push(c, 1'($urandom), 1'($urandom), 1'b1);
      end
    end
    play(name);
  endtask
  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({act, retired} !== '0) begin
        errs++;
        $display("FAIL %s reset outputs: got ctl %h retired %0d expected all zero", name, act, retired);
      end
      if (i < 2) @(negedge clk);
    end
    exp_ret = '0;
  endtask
  task automatic test_reset();
    do_reset("reset");
    instr(7'b0110011, 0, 0, 1'b0, "add");
  endtask
  task automatic test_lw_wait();
    instr(7'b0000011, 0, 3, 1'b0, "lw_wait");
    instr(7'b0100011, 2, 1, 1'b0, "sw_wait");
  endtask
  task automatic test_beq();
    instr(7'b1100011, 0, 0, 1'b1, "beq_taken");
    instr(7'b1100011, 0, 0, 1'b0, "beq_not_taken");
  endtask
  task automatic test_jal();
    instr(7'b1101111, 1, 0, 1'b0, "jal");
    instr(7'b0110111, 0, 0, 1'b0, "lui");
  endtask
  task automatic test_illegal();
    instr(7'b1111111, 0, 0, 1'b0, "illegal");
    do_reset("illegal_reset");
    instr(7'b0010011, 0, 0, 1'b0, "after_trap");
  endtask
  task automatic test_timeout();
    instr(7'b0110011, TO, 0, 1'b0, "fetch_timeout");
    do_reset("timeout_reset");
    instr(7'b0110011, TO - 1, 0, 1'b0, "fetch_late_ready");
    instr(7'b0000011, 0, TO, 1'b0, "mem_timeout");
    do_reset("mem_timeout_reset");
    instr(7'b0100011, 0, TO - 1, 1'b0, "mem_late_ready");
  endtask
  task automatic test_mid_request_reset();
    ctl_t c;
    cur_op = 7'b0110011;
    c = '0; c.req = 1'b1; c.b = 2'd2;
    push(c, 1'b0, 1'b0, 1'b0);
    push(c, 1'b0, 1'b0, 1'b0);
    play("mid_request");
    do_reset("mid_request_reset");
    instr(7'b0110011, 0, 0, 1'b0, "after_mid_reset");
  endtask
  task automatic test_random();
    for (int n = 0; n < 60; n++)
      instr(legal[$urandom_range(6)], $urandom_range(TO - 1), $urandom_range(TO - 1),
            1'($urandom), "random");
  endtask
  initial begin
    test_reset();
    test_lw_wait();
    test_beq();
    test_jal();
    test_illegal();
    test_timeout();
    test_mid_request_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
